// File: rtl/decode_regfile.sv
// ---------------------------------------------------------------------------
// decode_regfile
//
// Decode stage of a 5-stage Y86-64 pipeline. Holds the 15 x 64-bit
// architectural register file, derives the source/destination register IDs
// from the instruction fields, and resolves operand values through a
// fixed-priority forwarding network (execute > memory > writeback > array).
//
// Ports
//   CLK, RST            pipeline clock, asynchronous active-high reset
//   D_icode/D_rA/D_rB   instruction code and register specifiers in decode
//   D_valP              incremented PC (used as valA by jXX/call)
//   e_dstE/e_valE       execute-stage ALU destination and result
//   M_dstE/M_valE       memory-stage ALU destination and value
//   M_dstM/m_valM       memory-stage load destination and memory read data
//   W_dstE/W_valE       writeback ALU destination and value (writes array)
//   W_dstM/W_valM       writeback load destination and value (writes array)
//   d_srcA/d_srcB       selected source register IDs
//   d_dstE/d_dstM       selected destination register IDs
//   D_valA/D_valB       forwarded operands for the execute pipeline register
//
// Optional debug feature, enabled by defining REGFILE_DBG_EN:
//   dbg_addr            register index to observe
//   dbg_data            registered copy of regfile[dbg_addr] (0 for index F)
//   dbg_wr_count        running count of register writes accepted
//
// All decode outputs are combinational; the register array updates on the
// rising clock edge and is visible through the array one cycle later.
// ---------------------------------------------------------------------------
module decode_regfile #(
   parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_0100,
   parameter logic [3:0]  RNONE      = 4'hF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  D_icode,
   input  logic [3:0]  D_rA,
   input  logic [3:0]  D_rB,
   input  logic [63:0] D_valP,
   input  logic [3:0]  e_dstE,
   input  logic [63:0] e_valE,
   input  logic [3:0]  M_dstE,
   input  logic [63:0] M_valE,
   input  logic [3:0]  M_dstM,
   input  logic [63:0] m_valM,
   input  logic [3:0]  W_dstE,
   input  logic [63:0] W_valE,
   input  logic [3:0]  W_dstM,
   input  logic [63:0] W_valM,
   output logic [3:0]  d_srcA,
   output logic [3:0]  d_srcB,
   output logic [3:0]  d_dstE,
   output logic [3:0]  d_dstM,
   output logic [63:0] D_valA,
   output logic [63:0] D_valB
`ifdef REGFILE_DBG_EN
   ,
   input  logic [3:0]  dbg_addr,
   output logic [63:0] dbg_data,
   output logic [31:0] dbg_wr_count
`endif
);

   // Y86-64 instruction codes
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] R_RSP    = 4'h4;
   localparam int         NREGS    = 15;

   // Register array; index F has no storage.
   logic [63:0] r_regs [0:NREGS-1];

   logic [3:0]  w_src_a;
   logic [3:0]  w_src_b;
   logic [3:0]  w_dst_e;
   logic [3:0]  w_dst_m;
   logic [63:0] w_rf_a;
   logic [63:0] w_rf_b;
   logic [63:0] w_val_a;
   logic [63:0] w_val_b;

   // Register array writes from writeback; dstM beats dstE on a collision.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NREGS; i++) begin
            if (4'(i) == R_RSP) begin
               r_regs[i] <= STACK_INIT;
            end else begin
               r_regs[i] <= 64'h0;
            end
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (W_dstM == 4'(i)) begin
               r_regs[i] <= W_valM;
            end else if (W_dstE == 4'(i)) begin
               r_regs[i] <= W_valE;
            end else begin
               r_regs[i] <= r_regs[i];
            end
         end
      end
   end

   // Source/destination register selection from the instruction code.
   always_comb begin
      w_src_a = RNONE;
      w_src_b = RNONE;
      w_dst_e = RNONE;
      w_dst_m = RNONE;
      case (D_icode)
         I_RRMOVQ: begin
            w_src_a = D_rA;
            w_dst_e = D_rB;
         end
         I_IRMOVQ: begin
            w_dst_e = D_rB;
         end
         I_RMMOVQ: begin
            w_src_a = D_rA;
            w_src_b = D_rB;
         end
         I_MRMOVQ: begin
            w_src_b = D_rB;
            w_dst_m = D_rA;
         end
         I_OPQ: begin
            w_src_a = D_rA;
            w_src_b = D_rB;
            w_dst_e = D_rB;
         end
         I_CALL: begin
            w_src_b = R_RSP;
            w_dst_e = R_RSP;
         end
         I_RET: begin
            w_src_a = R_RSP;
            w_src_b = R_RSP;
            w_dst_e = R_RSP;
         end
         I_PUSHQ: begin
            w_src_a = D_rA;
            w_src_b = R_RSP;
            w_dst_e = R_RSP;
         end
         I_POPQ: begin
            w_src_a = R_RSP;
            w_src_b = R_RSP;
            w_dst_e = R_RSP;
            w_dst_m = D_rA;
         end
         default: begin
            // halt, nop, jXX and unknown codes touch no registers
            w_src_a = RNONE;
            w_src_b = RNONE;
            w_dst_e = RNONE;
            w_dst_m = RNONE;
         end
      endcase
   end

   // Combinational array reads; an F index falls through to zero.
   always_comb begin
      w_rf_a = 64'h0;
      w_rf_b = 64'h0;
      for (int i = 0; i < NREGS; i++) begin
         if (w_src_a == 4'(i)) begin
            w_rf_a = r_regs[i];
         end else begin
            w_rf_a = w_rf_a;
         end
         if (w_src_b == 4'(i)) begin
            w_rf_b = r_regs[i];
         end else begin
            w_rf_b = w_rf_b;
         end
      end
   end

   // Operand A: valP for jXX/call, then youngest-stage forwarding first.
   // Writeback forwarding also covers a same-cycle write/read of one register.
   always_comb begin
      w_val_a = w_rf_a;
      if (D_icode == I_JXX || D_icode == I_CALL) begin
         w_val_a = D_valP;
      end else if (w_src_a == RNONE) begin
         w_val_a = 64'h0;
      end else if (w_src_a == e_dstE) begin
         w_val_a = e_valE;
      end else if (w_src_a == M_dstM) begin
         w_val_a = m_valM;
      end else if (w_src_a == M_dstE) begin
         w_val_a = M_valE;
      end else if (w_src_a == W_dstM) begin
         w_val_a = W_valM;
      end else if (w_src_a == W_dstE) begin
         w_val_a = W_valE;
      end else begin
         w_val_a = w_rf_a;
      end
   end

   // Operand B: same forwarding priority as A, without the valP path.
   always_comb begin
      w_val_b = w_rf_b;
      if (w_src_b == RNONE) begin
         w_val_b = 64'h0;
      end else if (w_src_b == e_dstE) begin
         w_val_b = e_valE;
      end else if (w_src_b == M_dstM) begin
         w_val_b = m_valM;
      end else if (w_src_b == M_dstE) begin
         w_val_b = M_valE;
      end else if (w_src_b == W_dstM) begin
         w_val_b = W_valM;
      end else if (w_src_b == W_dstE) begin
         w_val_b = W_valE;
      end else begin
         w_val_b = w_rf_b;
      end
   end

   assign d_srcA = w_src_a;
   assign d_srcB = w_src_b;
   assign d_dstE = w_dst_e;
   assign d_dstM = w_dst_m;
   assign D_valA = w_val_a;
   assign D_valB = w_val_b;

`ifdef REGFILE_DBG_EN
   logic [63:0] w_dbg_rd;
   logic [1:0]  w_wr_inc;
   logic [63:0] r_dbg_data;
   logic [31:0] r_dbg_wr_count;

   // Debug read port mux; index F reads as zero.
   always_comb begin
      w_dbg_rd = 64'h0;
      for (int i = 0; i < NREGS; i++) begin
         if (dbg_addr == 4'(i)) begin
            w_dbg_rd = r_regs[i];
         end else begin
            w_dbg_rd = w_dbg_rd;
         end
      end
   end

   // Writes accepted this edge; a dstE/dstM collision is a single write.
   always_comb begin
      w_wr_inc = 2'd0;
      if (W_dstE != RNONE && W_dstM != RNONE && W_dstE != W_dstM) begin
         w_wr_inc = 2'd2;
      end else if (W_dstE != RNONE || W_dstM != RNONE) begin
         w_wr_inc = 2'd1;
      end else begin
         w_wr_inc = 2'd0;
      end
   end

   // Debug capture register and wrapping write counter.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_dbg_data     <= 64'h0;
         r_dbg_wr_count <= 32'h0;
      end else begin
         r_dbg_data     <= w_dbg_rd;
         r_dbg_wr_count <= r_dbg_wr_count + {30'd0, w_wr_inc};
      end
   end

   assign dbg_data     = r_dbg_data;
   assign dbg_wr_count = r_dbg_wr_count;
`else
   // Debug port, capture register and write counter are not built.
`endif

endmodule

// File: tb/tb_decode_regfile.sv
module tb_decode_regfile;

   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  D_icode, D_rA, D_rB;
   logic [63:0] D_valP;
   logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
   logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
   logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
   logic [63:0] D_valA, D_valB;
`ifdef REGFILE_DBG_EN
   logic [3:0]  dbg_addr;
   logic [63:0] dbg_data;
   logic [31:0] dbg_wr_count;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   decode_regfile dut (
      .CLK(CLK), .RST(RST),
      .D_icode(D_icode), .D_rA(D_rA), .D_rB(D_rB), .D_valP(D_valP),
      .e_dstE(e_dstE), .e_valE(e_valE),
      .M_dstE(M_dstE), .M_valE(M_valE),
      .M_dstM(M_dstM), .m_valM(m_valM),
      .W_dstE(W_dstE), .W_valE(W_valE),
      .W_dstM(W_dstM), .W_valM(W_valM),
      .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
      .D_valA(D_valA), .D_valB(D_valB)
`ifdef REGFILE_DBG_EN
      ,
      .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_wr_count(dbg_wr_count)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0]  srcA, srcB, dstE, dstM;
      logic [63:0] valA, valB;
   } exp_t;

   typedef struct {
      logic [3:0]  icode, rA, rB;
      logic [63:0] valP;
      logic [3:0]  e_dE;  logic [63:0] e_vE;
      logic [3:0]  M_dE;  logic [63:0] M_vE;
      logic [3:0]  M_dM;  logic [63:0] m_vM;
      logic [3:0]  W_dE;  logic [63:0] W_vE;
      logic [3:0]  W_dM;  logic [63:0] W_vM;
      exp_t        exp;
   } vec_t;

   localparam int NV = 16;
   vec_t vt [NV];
   exp_t sb [$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   task automatic idle();
      D_icode = 4'h1; D_rA = 4'hF; D_rB = 4'hF; D_valP = 64'h0;
      e_dstE = 4'hF; e_valE = 64'h0;
      M_dstE = 4'hF; M_valE = 64'h0; M_dstM = 4'hF; m_valM = 64'h0;
      W_dstE = 4'hF; W_valE = 64'h0; W_dstM = 4'hF; W_valM = 64'h0;
   endtask

   task automatic drive(input vec_t v);
      D_icode = v.icode; D_rA = v.rA; D_rB = v.rB; D_valP = v.valP;
      e_dstE = v.e_dE; e_valE = v.e_vE;
      M_dstE = v.M_dE; M_valE = v.M_vE; M_dstM = v.M_dM; m_valM = v.m_vM;
      W_dstE = v.W_dE; W_valE = v.W_vE; W_dstM = v.W_dM; W_valM = v.W_vM;
      sb.push_back(v.exp);
   endtask

   task automatic compare(input int idx);
      exp_t e;
      if (sb.size() == 0) begin
         n_chk++; n_fail++;
         $display("FAIL v%0d scoreboard: got empty queue, required one entry", idx);
      end else begin
         e = sb.pop_front();
         chk($sformatf("v%0d srcA", idx), {60'd0, d_srcA}, {60'd0, e.srcA});
         chk($sformatf("v%0d srcB", idx), {60'd0, d_srcB}, {60'd0, e.srcB});
         chk($sformatf("v%0d dstE", idx), {60'd0, d_dstE}, {60'd0, e.dstE});
         chk($sformatf("v%0d dstM", idx), {60'd0, d_dstM}, {60'd0, e.dstM});
         chk($sformatf("v%0d valA", idx), D_valA, e.valA);
         chk($sformatf("v%0d valB", idx), D_valB, e.valB);
      end
   endtask

   initial begin
      // icode rA rB valP | eE | ME MM | WE WM | srcA srcB dstE dstM valA valB
      vt[0]  = '{4'h1, 4'hF, 4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,    4'hF, 64'h0,
                 '{4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0}};
      vt[1]  = '{4'hA, 4'h3, 4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,    4'hF, 64'h0,
                 '{4'h3, 4'h4, 4'h4, 4'hF, 64'h0, 64'h100}};
      vt[2]  = '{4'h0, 4'hF, 4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'h2, 64'hDEAD, 4'hF, 64'h0,
                 '{4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0}};
      vt[3]  = '{4'h6, 4'h2, 4'h3, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,    4'hF, 64'h0,
                 '{4'h2, 4'h3, 4'h3, 4'hF, 64'hDEAD, 64'h0}};
      vt[4]  = '{4'h6, 4'h5, 4'h5, 64'h0,  4'h5, 64'h1,  4'h5, 64'h2,  4'hF, 64'h0,  4'h5, 64'h3,    4'hF, 64'h0,
                 '{4'h5, 4'h5, 4'h5, 4'hF, 64'h1, 64'h1}};
      vt[5]  = '{4'h6, 4'h5, 4'h5, 64'h0,  4'hF, 64'h1,  4'h5, 64'h2,  4'hF, 64'h0,  4'h5, 64'h3,    4'hF, 64'h0,
                 '{4'h5, 4'h5, 4'h5, 4'hF, 64'h2, 64'h2}};
      vt[6]  = '{4'hB, 4'h4, 4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'h4, 64'h108,  4'h4, 64'h55,
                 '{4'h4, 4'h4, 4'h4, 4'h4, 64'h55, 64'h55}};
      vt[7]  = '{4'h2, 4'h4, 4'h6, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,    4'hF, 64'h0,
                 '{4'h4, 4'hF, 4'h6, 4'hF, 64'h55, 64'h0}};
      vt[8]  = '{4'h8, 4'hF, 4'hF, 64'h40, 4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,    4'hF, 64'h0,
                 '{4'hF, 4'h4, 4'h4, 4'hF, 64'h40, 64'h55}};
      vt[9]  = '{4'hC, 4'h1, 4'h2, 64'h0,  4'hF, 64'h77, 4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,    4'hF, 64'h0,
                 '{4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0}};
      vt[10] = '{4'h5, 4'h7, 4'h5, 64'h0,  4'hF, 64'h0,  4'h5, 64'hBB, 4'h5, 64'hAA, 4'hF, 64'h0,    4'hF, 64'h0,
                 '{4'hF, 4'h5, 4'hF, 4'h7, 64'h0, 64'hAA}};
      vt[11] = '{4'h4, 4'h2, 4'h3, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'h2, 64'h22,   4'h2, 64'h11,
                 '{4'h2, 4'h3, 4'hF, 4'hF, 64'h11, 64'h0}};
      vt[12] = '{4'h7, 4'hF, 4'hF, 64'h99, 4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,    4'hF, 64'h0,
                 '{4'hF, 4'hF, 4'hF, 4'hF, 64'h99, 64'h0}};
      vt[13] = '{4'h9, 4'hF, 4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'h7, 64'h9,    4'hF, 64'h0,
                 '{4'h4, 4'h4, 4'h4, 4'hF, 64'h55, 64'h55}};
      vt[14] = '{4'h6, 4'h2, 4'h1, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,    4'hF, 64'h0,
                 '{4'h2, 4'h1, 4'h1, 4'hF, 64'h11, 64'h0}};
      vt[15] = '{4'h2, 4'h7, 4'h2, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,  4'hF, 64'h0,    4'hF, 64'h0,
                 '{4'h7, 4'hF, 4'h2, 4'hF, 64'h9, 64'h0}};

      RST = 1'b1;
      idle();
`ifdef REGFILE_DBG_EN
      dbg_addr = 4'hF;
`endif
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;

      // Table vectors: one per cycle; writeback effects land on the next edge.
      for (int i = 0; i < NV; i++) begin
         @(posedge CLK);
         #1 drive(vt[i]);
         @(negedge CLK);
         compare(i);
      end

      // Asynchronous reset mid-run: reg7 (holding 9) reads 0 without an edge.
      RST = 1'b1;
      #1 chk("async rst reg7", D_valA, 64'h0);
      // Reset holds off a writeback arriving on an edge.
      W_dstE = 4'h7; W_valE = 64'h5;
      @(posedge CLK);
      #1 W_dstE = 4'hF; W_valE = 64'h0;
      RST = 1'b0;
      #1 chk("rst beats write reg7", D_valA, 64'h0);
      D_icode = 4'hA; D_rA = 4'h3;
      #1 chk("rsp reinit", D_valB, 64'h100);
      D_rA = 4'h2;
      #1 chk("reg2 cleared", D_valA, 64'h0);

`ifdef REGFILE_DBG_EN
      chk("dbg count after reset", {32'd0, dbg_wr_count}, 64'd0);
      @(posedge CLK); #1 W_dstE = 4'h1; W_valE = 64'h1;
      @(posedge CLK); #1 W_dstE = 4'h4; W_valE = 64'h108; W_dstM = 4'h4; W_valM = 64'h77;
      @(posedge CLK); #1 W_dstE = 4'h3; W_valE = 64'h3;   W_dstM = 4'hF; W_valM = 64'h0;
      @(posedge CLK); #1 W_dstE = 4'hF; dbg_addr = 4'h4;
      @(posedge CLK); #1;
      chk("dbg_wr_count", {32'd0, dbg_wr_count}, 64'd3);
      chk("dbg_data reg4", dbg_data, 64'h77);
      dbg_addr = 4'hF;
      @(posedge CLK); #1;
      chk("dbg_data addr F", dbg_data, 64'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_regfile.md
Name: decode_regfile

Overview:
- Decode-stage block of the 5-stage Y86-64 pipeline. Produces the D_-side operands that the decode→execute pipeline register captures on each CLK edge.
- Holds the 15×64-bit architectural register file, written from the writeback stage.
- Generates srcA/srcB/dstE/dstM from icode/rA/rB.
- Selects valA/valB using a fixed-priority forwarding network fed by the execute, memory and writeback stages.

Parameters:
- STACK_INIT, 64'h0000_0000_0000_0100, reset value of %rsp (reg 4).
- RNONE, 4'hF, "no register" encoding. Never stored.

Ports:
- CLK  input  1  pipeline clock
- RST  input  1  asynchronous active-high reset
- D_icode  input  4  instruction code in decode
- D_rA  input  4  register specifier A
- D_rB  input  4  register specifier B
- D_valP  input  64  incremented PC
- e_dstE  input  4  execute-stage destination E
- e_valE  input  64  ALU result in execute
- M_dstE  input  4  memory-stage dstE
- M_valE  input  64  memory-stage valE
- M_dstM  input  4  memory-stage dstM
- m_valM  input  64  data-memory read value
- W_dstE  input  4  writeback dstE
- W_valE  input  64  writeback valE
- W_dstM  input  4  writeback dstM
- W_valM  input  64  writeback valM
- d_srcA  output  4  source A selected
- d_srcB  output  4  source B selected
- d_dstE  output  4  destination E
- d_dstM  output  4  destination M
- D_valA  output  64  operand A to execute register
- D_valB  output  64  operand B to execute register

Behaviour:
- Reset (RST=1, async): regs 0–14 ← 0, except reg 4 ← STACK_INIT. Reset has priority over any write in flight.
- Post-reset outputs, with D_icode=1 and all stage dsts = F: d_srcA, d_srcB, d_dstE and d_dstM = F; D_valA = D_valB = 0.
- Writes occur on posedge CLK only:
  - W_dstE≠F: reg[W_dstE] ← W_valE.
  - W_dstM≠F: reg[W_dstM] ← W_valM.
  - W_dstE==W_dstM≠F: W_valM wins (popq %rsp semantics).
- Index F is never written.
- Reads are combinational from the array. A read of F returns 0.
- d_srcA:
  - rA for icode {2,4,6,A}.
  - 4 for {9,B}.
  - F otherwise.
- d_srcB:
  - rB for {4,5,6}.
  - 4 for {8,9,A,B}.
  - F otherwise.
- d_dstE:
  - rB for {2,3,6}. A cmov's condition is squashed downstream, not here.
  - 4 for {8,9,A,B}.
  - F otherwise.
- d_dstM: rA for {5,B}, F otherwise.
- D_valA priority:
  1. icode∈{7,8} → D_valP
  2. srcA==e_dstE → e_valE
  3. ==M_dstM → m_valM
  4. ==M_dstE → M_valE
  5. ==W_dstM → W_valM
  6. ==W_dstE → W_valE
  7. otherwise regfile[srcA]
- Each forwarding match requires srcA≠F.
- D_valB: same chain on srcB, without the valP step.
- Same-cycle write/read of one register: the array returns the old value, and W forwarding supplies the new value. Net result: D_valA/D_valB always show the post-write value.
- Latency: outputs are combinational, 0 cycles. Register updates are visible through the array 1 cycle after the write edge.
- Unknown icodes (C–F): all src/dst = F, D_valA = D_valB = 0.
- Stall and bubble handling is outside this block.

Optional Feature:
- Macro: REGFILE_DBG_EN.
- Defined: adds three ports.
  - dbg_addr input 4.
  - dbg_data output 64: registered. Captures regfile[dbg_addr] on posedge CLK, 1-cycle latency. Returns 0 for address F.
  - dbg_wr_count output 32: increments by the number of real writes accepted per edge (0, 1 or 2; a collision counts 1). Wraps 32'hFFFF_FFFF→0.
  - Both dbg_data and dbg_wr_count reset to 0.
- Undefined: ports absent; no counter or debug flops are synthesised.

Test Plan:
- Reset release, icode=A, rA=3 → d_srcA=3, d_srcB=4, d_dstE=4, D_valB=64'h100, D_valA=0.
- Write W_dstE=2, W_valE=64'hDEAD for one edge. Next cycle icode=6, rA=2, no forwarding → D_valA=64'hDEAD.
- icode=6, rA=rB=5, e_dstE=5/e_valE=1, M_dstE=5/M_valE=2, W_dstE=5/W_valE=3 → D_valA=D_valB=1. Then drop e_dstE → both 2.
- icode=B with W_dstE=4/W_valE=64'h108 and W_dstM=4/W_valM=64'h55 in the same edge → reg4=64'h55 afterward.
- icode=8, D_valP=64'h40, e_dstE=F → D_valA=64'h40, d_srcB=4. Assert RST mid-run after writing reg7=9 → reg7 reads 0 immediately.
- With REGFILE_DBG_EN: 3 writes (one of them a collision), dbg_addr=4 → dbg_wr_count=3, dbg_data valid one edge after dbg_addr is applied.
